// File: rtl/systolic_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg
// Shared types and helpers for the output-stationary systolic PE.
//   pe_state_t : accumulator FSM state (IDLE = no partial sum, ACC = live sum)
//   sat_max    : largest representable OP_SIZE-bit value (signed or unsigned)
//   sat_min    : smallest representable OP_SIZE-bit value (signed or unsigned)
//   widths_ok  : accumulator must hold a full product without truncation
// sat_max/sat_min return a 64-bit pattern; callers keep the low OP_SIZE bits.
// ---------------------------------------------------------------------------
package systolic_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } pe_state_t;

    localparam int SAT_W = 64;

    // All-ones shifted down to the magnitude field: 2^(n-1)-1 signed, 2^n-1 unsigned.
    function automatic logic [SAT_W-1:0] sat_max(input int opSize, input bit isSigned);
        logic [SAT_W-1:0] ones;
        ones = '1;
        if (isSigned)
            return ones >> (SAT_W - opSize + 1);
        else
            return ones >> (SAT_W - opSize);
    endfunction

    // Complement of the signed maximum leaves 100..0 in the low opSize bits.
    function automatic logic [SAT_W-1:0] sat_min(input int opSize, input bit isSigned);
        if (isSigned)
            return ~sat_max(opSize, 1'b1);
        else
            return '0;
    endfunction

    function automatic bit widths_ok(input int ipSize, input int opSize);
        return opSize >= 2 * ipSize;
    endfunction

endpackage

// File: rtl/pe_mul.sv
// ---------------------------------------------------------------------------
// pe_mul
// Operand multiplier for the systolic PE. Forms the full 2*IP_SIZE product
// (signed or unsigned), extends it to OP_SIZE and optionally registers it
// together with its valid/last tags.
//   clk, rst        : clock, async active-high reset (used only if MUL_PIPE=1)
//   valid_i, last_i : beat qualifiers entering the multiplier
//   x_i, w_i        : IP_SIZE-bit operands
//   prod_o          : OP_SIZE-bit extended product at the accumulator stage
//   valid_o, last_o : beat qualifiers aligned with prod_o (last_o is valid-gated)
// ---------------------------------------------------------------------------
module pe_mul
    import systolic_pkg::*;
#(
    parameter int IP_SIZE  = 8,
    parameter int OP_SIZE  = 24,
    parameter bit SIGNED   = 1'b1,
    parameter int MUL_PIPE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    input  logic               last_i,
    input  logic [IP_SIZE-1:0] x_i,
    input  logic [IP_SIZE-1:0] w_i,
    output logic [OP_SIZE-1:0] prod_o,
    output logic               valid_o,
    output logic               last_o
);

    logic [OP_SIZE-1:0] prodExt;

    // Operands are widened to OP_SIZE before multiplying; since OP_SIZE is at
    // least twice the operand width the low OP_SIZE bits are the exact product,
    // already sign- or zero-extended.
    generate
        if (SIGNED) begin : gSigned
            assign prodExt = OP_SIZE'($signed(x_i)) * OP_SIZE'($signed(w_i));
        end else begin : gUnsigned
            assign prodExt = OP_SIZE'(x_i) * OP_SIZE'(w_i);
        end
    endgenerate

    generate
        if (MUL_PIPE != 0) begin : gPipe
            logic [OP_SIZE-1:0] prod_q;
            logic               valid_q;
            logic               last_q;

            // Product and its tags move as one so the accumulator always sees
            // a coherent beat one cycle after the operands arrive.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    prod_q  <= '0;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end else begin
                    prod_q  <= prodExt;
                    valid_q <= valid_i;
                    last_q  <= last_i & valid_i;
                end
            end

            assign prod_o  = prod_q;
            assign valid_o = valid_q;
            assign last_o  = last_q;
        end else begin : gComb
            assign prod_o  = prodExt;
            assign valid_o = valid_i;
            assign last_o  = last_i & valid_i;
        end
    endgenerate

endmodule

// File: rtl/systolic_pe_os.sv
// ---------------------------------------------------------------------------
// systolic_pe_os
// Output-stationary systolic processing element. Forwards operands and tags to
// east/south neighbours with one cycle of latency, accumulates x*w over groups
// framed by in_last and offers each finished dot product through a one-entry
// valid/ready result register. A result arriving while the register is still
// full and not being drained is dropped and flagged on the sticky ovf_err.
//   clk, rst              : clock, async active-high reset
//   in_valid, in_last     : beat qualifiers (in_last only counts with in_valid)
//   acc_clear             : synchronous discard of the partial sum
//   x_new, w_new          : operands from west / north
//   x_old, w_old          : registered operands to east / south
//   valid_old, last_old   : registered beat qualifiers to neighbours
//   acc_valid, acc_ready  : result handshake with the drain network
//   acc_data              : finished dot product
//   ovf_err               : sticky lost-result flag
// Build option: define PE_SAT_EN to clamp every accumulate to the OP_SIZE
// range instead of wrapping.
// ---------------------------------------------------------------------------
module systolic_pe_os
    import systolic_pkg::*;
#(
    parameter int IP_SIZE  = 8,
    parameter int OP_SIZE  = 24,
    parameter bit SIGNED   = 1'b1,
    parameter int MUL_PIPE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_last,
    input  logic               acc_clear,
    input  logic [IP_SIZE-1:0] x_new,
    input  logic [IP_SIZE-1:0] w_new,
    output logic [IP_SIZE-1:0] x_old,
    output logic [IP_SIZE-1:0] w_old,
    output logic               valid_old,
    output logic               last_old,
    output logic               acc_valid,
    input  logic               acc_ready,
    output logic [OP_SIZE-1:0] acc_data,
    output logic               ovf_err
);

    generate
        if (!widths_ok(IP_SIZE, OP_SIZE)) begin : gBadWidth
            $error("systolic_pe_os: OP_SIZE must be at least 2*IP_SIZE");
        end
    endgenerate

`ifdef PE_SAT_EN
    localparam logic [OP_SIZE-1:0] SAT_MAX = OP_SIZE'(sat_max(OP_SIZE, SIGNED));
    localparam logic [OP_SIZE-1:0] SAT_MIN = OP_SIZE'(sat_min(OP_SIZE, SIGNED));
`endif

    // One accumulate step. With saturation the add is done one bit wider so
    // overflow can be seen and replaced by the nearest range limit.
    function automatic logic [OP_SIZE-1:0] addStep(input logic [OP_SIZE-1:0] a,
                                                   input logic [OP_SIZE-1:0] b);
`ifdef PE_SAT_EN
        logic [OP_SIZE:0]   wide;
        logic [OP_SIZE-1:0] res;
        if (SIGNED) begin
            wide = {a[OP_SIZE-1], a} + {b[OP_SIZE-1], b};
            if (wide[OP_SIZE] != wide[OP_SIZE-1])
                res = wide[OP_SIZE] ? SAT_MIN : SAT_MAX;
            else
                res = wide[OP_SIZE-1:0];
        end else begin
            wide = {1'b0, a} + {1'b0, b};
            res  = wide[OP_SIZE] ? SAT_MAX : wide[OP_SIZE-1:0];
        end
        return res;
`else
        return a + b;
`endif
    endfunction

    logic [IP_SIZE-1:0] xOld_q, wOld_q;
    logic               validOld_q, lastOld_q;
    logic [OP_SIZE-1:0] mulProd;
    logic               mulValid, mulLast;
    pe_state_t          state_q, state_d;
    logic [OP_SIZE-1:0] sum_q, sum_d;
    logic [OP_SIZE-1:0] base, total;
    logic               complete;
    logic               accValid_q, accValid_d;
    logic [OP_SIZE-1:0] accData_q, accData_d;
    logic               ovf_q, ovf_d;

    pe_mul #(
        .IP_SIZE (IP_SIZE),
        .OP_SIZE (OP_SIZE),
        .SIGNED  (SIGNED),
        .MUL_PIPE(MUL_PIPE)
    ) uMul (
        .clk    (clk),
        .rst    (rst),
        .valid_i(in_valid),
        .last_i (in_last),
        .x_i    (x_new),
        .w_i    (w_new),
        .prod_o (mulProd),
        .valid_o(mulValid),
        .last_o (mulLast)
    );

    // Neighbour forwarding runs every cycle so the PE never stalls the array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xOld_q     <= '0;
            wOld_q     <= '0;
            validOld_q <= 1'b0;
            lastOld_q  <= 1'b0;
        end else begin
            xOld_q     <= x_new;
            wOld_q     <= w_new;
            validOld_q <= in_valid;
            lastOld_q  <= in_last & in_valid;
        end
    end

    // Accumulator FSM. A clear zeroes the running base, so a beat arriving
    // alongside it starts a fresh group; a last beat hands the total to the
    // result path and returns to IDLE with an empty sum.
    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        base     = '0;
        total    = '0;
        complete = 1'b0;
        if (state_q == ACC && !acc_clear)
            base = sum_q;
        if (acc_clear) begin
            state_d = IDLE;
            sum_d   = '0;
        end
        if (mulValid) begin
            total = addStep(base, mulProd);
            if (mulLast) begin
                complete = 1'b1;
                state_d  = IDLE;
                sum_d    = '0;
            end else begin
                state_d = ACC;
                sum_d   = total;
            end
        end
    end

    // Result holding register. A handshake frees the slot in the same cycle a
    // new result may land; with no room the new result is dropped and flagged.
    always_comb begin
        accValid_d = accValid_q;
        accData_d  = accData_q;
        ovf_d      = ovf_q;
        if (accValid_q && acc_ready)
            accValid_d = 1'b0;
        if (complete) begin
            if (!accValid_q || acc_ready) begin
                accData_d  = total;
                accValid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // State for the accumulator and result path; reset abandons any group.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sum_q      <= '0;
            accValid_q <= 1'b0;
            accData_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            accValid_q <= accValid_d;
            accData_q  <= accData_d;
            ovf_q      <= ovf_d;
        end
    end

    assign x_old     = xOld_q;
    assign w_old     = wOld_q;
    assign valid_old = validOld_q;
    assign last_old  = lastOld_q;
    assign acc_valid = accValid_q;
    assign acc_data  = accData_q;
    assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_systolic_pe_os.sv
// ---------------------------------------------------------------------------
// tb_systolic_pe_os
// Directed bench for systolic_pe_os. Three instances share one stimulus
// stream: dut (defaults: 8/24, signed, piped), dutU (8/16, unsigned,
// combinational product) and dutS (8/16, signed, piped). Expected values are
// hand-computed constants. Honors PE_SAT_EN for the saturation vector.
// ---------------------------------------------------------------------------
module tb_systolic_pe_os;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        inValid = 1'b0;
    logic        inLast = 1'b0;
    logic        accClear = 1'b0;
    logic        accReady = 1'b1;
    logic [7:0]  xNew = '0;
    logic [7:0]  wNew = '0;

    logic [7:0]  xOld, wOld, xOldU, wOldU, xOldS, wOldS;
    logic        validOld, lastOld, validOldU, lastOldU, validOldS, lastOldS;
    logic        accValid, accValidU, accValidS;
    logic [23:0] accData;
    logic [15:0] accDataU, accDataS;
    logic        ovfErr, ovfErrU, ovfErrS;

    int vectorCount = 0;
    int missCount   = 0;

`ifdef PE_SAT_EN
    localparam logic [15:0] SAT_EXP_S = 16'h7FFF;
`else
    localparam logic [15:0] SAT_EXP_S = 16'hBD03;
`endif

    systolic_pe_os #(.IP_SIZE(8), .OP_SIZE(24), .SIGNED(1'b1), .MUL_PIPE(1)) dut (
        .clk(clock), .rst(reset), .in_valid(inValid), .in_last(inLast),
        .acc_clear(accClear), .x_new(xNew), .w_new(wNew),
        .x_old(xOld), .w_old(wOld), .valid_old(validOld), .last_old(lastOld),
        .acc_valid(accValid), .acc_ready(accReady), .acc_data(accData),
        .ovf_err(ovfErr)
    );

    systolic_pe_os #(.IP_SIZE(8), .OP_SIZE(16), .SIGNED(1'b0), .MUL_PIPE(0)) dutU (
        .clk(clock), .rst(reset), .in_valid(inValid), .in_last(inLast),
        .acc_clear(accClear), .x_new(xNew), .w_new(wNew),
        .x_old(xOldU), .w_old(wOldU), .valid_old(validOldU), .last_old(lastOldU),
        .acc_valid(accValidU), .acc_ready(accReady), .acc_data(accDataU),
        .ovf_err(ovfErrU)
    );

    systolic_pe_os #(.IP_SIZE(8), .OP_SIZE(16), .SIGNED(1'b1), .MUL_PIPE(1)) dutS (
        .clk(clock), .rst(reset), .in_valid(inValid), .in_last(inLast),
        .acc_clear(accClear), .x_new(xNew), .w_new(wNew),
        .x_old(xOldS), .w_old(wOldS), .valid_old(validOldS), .last_old(lastOldS),
        .acc_valid(accValidS), .acc_ready(accReady), .acc_data(accDataS),
        .ovf_err(ovfErrS)
    );

    // Free-running 10-time-unit clock.
    always #5 clock = ~clock;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected sequence end");
        $fatal(1, "[TB] watchdog expired");
    end

    // Count one comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and return just after the
    // rising edge that captures them.
    task automatic applyStimulus(input logic v, input logic l, input logic clr,
                                 input logic [7:0] x, input logic [7:0] w);
        @(negedge clock);
        inValid  = v;
        inLast   = l;
        accClear = clr;
        xNew     = x;
        wNew     = w;
        @(posedge clock);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    endtask

    // Directed sequence.
    initial begin
        $display("[TB] start");
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst acc_valid", {31'd0, accValid}, 32'd0);
        checkOutput("rst acc_data", {8'd0, accData}, 32'd0);
        checkOutput("rst ovf_err", {31'd0, ovfErr}, 32'd0);
        checkOutput("rst x_old", {24'd0, xOld}, 32'd0);
        checkOutput("rst valid_old", {31'd0, validOld}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Four-beat dot product: 2+12+30+56 = 100.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd1, 8'd2);
        checkOutput("fwd x beat1", {24'd0, xOld}, 32'd1);
        checkOutput("fwd w beat1", {24'd0, wOld}, 32'd2);
        checkOutput("fwd valid beat1", {31'd0, validOld}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd3, 8'd4);
        checkOutput("fwd x beat2", {24'd0, xOld}, 32'd3);
        checkOutput("fwd last beat2", {31'd0, lastOld}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd5, 8'd6);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd7, 8'd8);
        checkOutput("fwd last beat4", {31'd0, lastOld}, 32'd1);
        checkOutput("pipe not yet valid", {31'd0, accValid}, 32'd0);
        checkOutput("comb valid n+1", {31'd0, accValidU}, 32'd1);
        checkOutput("comb data 100", {16'd0, accDataU}, 32'd100);
        idleCycle();
        checkOutput("pipe valid n+2", {31'd0, accValid}, 32'd1);
        checkOutput("pipe data 100", {8'd0, accData}, 32'd100);
        checkOutput("fwd valid idle", {31'd0, validOld}, 32'd0);
        idleCycle();
        checkOutput("valid one pulse", {31'd0, accValid}, 32'd0);

        // Mixed-sign operands: signed -12-10=-22, unsigned 1012+502=1514.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hFD, 8'h04);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h02, 8'hFB);
        checkOutput("unsigned 1514", {16'd0, accDataU}, 32'd1514);
        idleCycle();
        checkOutput("signed -22 op24", {8'd0, accData}, 32'h00FF_FFEA);
        checkOutput("signed -22 op16", {16'd0, accDataS}, 32'h0000_FFEA);
        idleCycle();

        // Single-beat group then a fresh group with no carry-over.
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd9, 8'd9);
        idleCycle();
        checkOutput("single beat 81", {8'd0, accData}, 32'd81);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd2, 8'd3);
        idleCycle();
        checkOutput("fresh group 6", {8'd0, accData}, 32'd6);
        idleCycle();

        // Back-to-back completions: second lands during the first's handshake.
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd4, 8'd4);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd5, 8'd5);
        checkOutput("b2b first 16", {8'd0, accData}, 32'd16);
        idleCycle();
        checkOutput("b2b second 25", {8'd0, accData}, 32'd25);
        checkOutput("b2b still valid", {31'd0, accValid}, 32'd1);
        idleCycle();
        checkOutput("b2b no overflow", {31'd0, ovfErr}, 32'd0);

        // Full register with no drain: B=20 is lost, A=10 stays.
        accReady = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd1, 8'd10);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd2, 8'd10);
        idleCycle();
        checkOutput("ovf keeps A", {8'd0, accData}, 32'd10);
        checkOutput("ovf flag set", {31'd0, ovfErr}, 32'd1);
        accReady = 1'b1;
        idleCycle();
        checkOutput("ovf drained", {31'd0, accValid}, 32'd0);
        checkOutput("ovf sticky", {31'd0, ovfErr}, 32'd1);
        idleCycle();

        // Clear mid-group discards 25+25; the following group yields 4.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd5, 8'd5);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd5, 8'd5);
        idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd2, 8'd2);
        idleCycle();
        checkOutput("clear then 4", {8'd0, accData}, 32'd4);
        idleCycle();

        // Clear coinciding with a beat at the accumulator stage starts a new
        // group with it: comb PE sees 3*3 alone, piped PE sees 25 then +9.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd5, 8'd5);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd3, 8'd3);
        checkOutput("clear+beat comb 9", {16'd0, accDataU}, 32'd9);
        idleCycle();
        checkOutput("clear+beat pipe 34", {8'd0, accData}, 32'd34);
        idleCycle();

        // Asynchronous reset mid-group clears everything at once.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd6, 8'd6);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd6, 8'd6);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async rst x_old", {24'd0, xOld}, 32'd0);
        checkOutput("async rst valid_old", {31'd0, validOld}, 32'd0);
        checkOutput("async rst ovf_err", {31'd0, ovfErr}, 32'd0);
        checkOutput("async rst acc_data", {8'd0, accData}, 32'd0);
        @(negedge clock);
        inValid = 1'b0;
        reset   = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd3, 8'd4);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd1, 8'd1);
        idleCycle();
        checkOutput("post rst 13", {8'd0, accData}, 32'd13);
        idleCycle();

        // 3 x 127*127 = 48387: fits 24 bits, wraps or clamps at 16 signed.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd127, 8'd127);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd127, 8'd127);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd127, 8'd127);
        checkOutput("unsigned 48387", {16'd0, accDataU}, 32'd48387);
        idleCycle();
        checkOutput("op24 48387", {8'd0, accData}, 32'd48387);
        checkOutput("op16 signed big", {16'd0, accDataS}, {16'd0, SAT_EXP_S});
        idleCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
